// File: rtl/sdft_spectrum_sequencer.sv
// Sequencer between the ADC sample stream, an sdft core and the bar-display frequency BRAM.
// Steps the sdft once per sample and periodically reads one bin, post-processes it and stores it.
module sdft_spectrum_sequencer #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned FREQ_W        = 16,
  parameter int unsigned BINS          = 16,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned UPDATE_PERIOD = 64,
  parameter int unsigned MAG_SHIFT     = 8,
  parameter int unsigned OUT_W         = 10,
  parameter int unsigned DECAY_SHIFT   = 3,
  parameter int unsigned AVG_SHIFT     = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic        [DATA_W-1:0] sample_in,
  input  logic                     blank,
  input  logic        [1:0]        mode,
  input  logic                     fft_ready,
  output logic                     fft_start,
  output logic        [DATA_W-1:0] fft_sample,
  output logic                     fft_read,
  output logic        [ADDR_W-1:0] fft_bin_addr,
  input  logic signed [FREQ_W-1:0] bin_real,
  input  logic signed [FREQ_W-1:0] bin_imag,
  output logic                     bram_w_en,
  output logic        [ADDR_W-1:0] bram_w_addr,
  output logic        [OUT_W-1:0]  bram_w_data,
  output logic                     frame_done
);

  localparam int unsigned CNT_W  = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int unsigned PROD_W = 2 * FREQ_W;
  localparam int unsigned SQ_W   = PROD_W + 1;

  localparam logic [CNT_W-1:0]  CntLast = CNT_W'(UPDATE_PERIOD - 1);
  localparam logic [ADDR_W-1:0] BinLast = ADDR_W'(BINS - 1);
  localparam logic [OUT_W-1:0]  OutMax  = '1;

  typedef enum logic [2:0] {
    StWait,
    StBusy,
    StRun,
    StRead,
    StMag,
    StProc,
    StWrite
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  step_cnt_q;
  logic [ADDR_W-1:0] bin_idx_q;
  logic [OUT_W-1:0]  mag_q;
  logic [OUT_W-1:0]  history_q [BINS];

  // Magnitude squared: both squares are non-negative, so the sum is treated as unsigned.
  logic signed [PROD_W-1:0] re_sq;
  logic signed [PROD_W-1:0] im_sq;
  logic        [SQ_W-1:0]   mag_sum;
  logic        [SQ_W-1:0]   mag_shr;
  logic        [OUT_W-1:0]  mag_sat;

  assign re_sq   = bin_real * bin_real;
  assign im_sq   = bin_imag * bin_imag;
  assign mag_sum = {1'b0, re_sq} + {1'b0, im_sq};
  assign mag_shr = mag_sum >> MAG_SHIFT;
  assign mag_sat = (|mag_shr[SQ_W-1:OUT_W]) ? OutMax : mag_shr[OUT_W-1:0];

  logic        [OUT_W-1:0] hist_cur;
  logic        [OUT_W-1:0] decay;
  logic        [OUT_W-1:0] peak;
  logic signed [OUT_W:0]   avg_diff;
  logic signed [OUT_W:0]   avg_sum;
  logic        [OUT_W-1:0] avg;
  logic        [OUT_W-1:0] proc_res;

  always_comb begin
    hist_cur = history_q[bin_idx_q];
    decay    = hist_cur - (hist_cur >> DECAY_SHIFT);
    // Small values have a zero decay term; step down by one so a silent bin reaches zero.
    if (mag_q == '0 && hist_cur != '0 && (hist_cur >> DECAY_SHIFT) == '0) begin
      decay = hist_cur - 1'b1;
    end
    peak     = (mag_q > decay) ? mag_q : decay;
    avg_diff = $signed({1'b0, mag_q}) - $signed({1'b0, hist_cur});
    avg_sum  = $signed({1'b0, hist_cur}) + (avg_diff >>> AVG_SHIFT);
    // The average lies between h and m, so only the negative side can need clamping.
    avg      = avg_sum[OUT_W] ? '0 : avg_sum[OUT_W-1:0];
    case (mode)
      2'd0:    proc_res = mag_q;
      2'd1:    proc_res = peak;
      2'd2:    proc_res = avg;
      default: proc_res = hist_cur;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StWait;
      step_cnt_q   <= '0;
      bin_idx_q    <= '0;
      mag_q        <= '0;
      fft_start    <= 1'b0;
      fft_sample   <= '0;
      fft_read     <= 1'b0;
      fft_bin_addr <= '0;
      bram_w_en    <= 1'b0;
      bram_w_addr  <= '0;
      bram_w_data  <= '0;
      frame_done   <= 1'b0;
      for (int i = 0; i < BINS; i++) begin
        history_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StWait: begin
          if (fft_ready) begin
            fft_sample <= sample_in;
            fft_start  <= 1'b1;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (!fft_ready) begin
            fft_start <= 1'b0;
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (fft_ready) begin
            // A due read waits for blanking; the counter holds at its last value meanwhile.
            if (step_cnt_q == CntLast && blank) begin
              step_cnt_q   <= '0;
              fft_read     <= 1'b1;
              fft_bin_addr <= bin_idx_q;
              state_q      <= StRead;
            end else begin
              if (step_cnt_q != CntLast) begin
                step_cnt_q <= step_cnt_q + 1'b1;
              end
              state_q <= StWait;
            end
          end
        end
        StRead: begin
          fft_read <= 1'b0;
          state_q  <= StMag;
        end
        StMag: begin
          mag_q   <= mag_sat;
          state_q <= StProc;
        end
        StProc: begin
          if (mode != 2'd3) begin
            history_q[bin_idx_q] <= proc_res;
            bram_w_en            <= 1'b1;
            bram_w_addr          <= bin_idx_q;
            bram_w_data          <= proc_res;
          end
          frame_done <= (bin_idx_q == BinLast);
          state_q    <= StWrite;
        end
        StWrite: begin
          bram_w_en  <= 1'b0;
          frame_done <= 1'b0;
          bin_idx_q  <= (bin_idx_q == BinLast) ? '0 : bin_idx_q + 1'b1;
          state_q    <= StWait;
        end
        default: begin
          state_q <= StWait;
        end
      endcase
    end
  end

endmodule
